de_sram_driver: RTL and testbench
=================================

# de_sram_driver

Memory-side responder for the drawing-engine request port: accepts one `de_req` transaction at a time from the drawing multiplexer, runs a timed access on an external 32-bit asynchronous SRAM frame store and returns `de_ack` (plus `de_rd_data` for reads). It sits between the drawing mux output (`de_*`) and the board SRAM pins.

## Interface
Parameters:
- `RD_WAIT`, default 2: cycles `sram_noe` is held low per read; legal 1..15.
- `WR_WAIT`, default 2: cycles `sram_nwe` is held low per write; legal 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `de_req`  in  1  transaction request (level).
- `de_ack`  out  1  one-cycle completion pulse.
- `de_rnw`  in  1  1 = read, 0 = write.
- `de_addr`  in  18  word address.
- `de_nbyte`  in  4  active-low byte enables, bit n = byte lane n (`[8n+7:8n]`).
- `de_data`  in  32  write data.
- `de_rd_data`  out  32  read data, valid in the `de_ack` cycle and held until the next read completes.
- `sram_addr`  out  18  SRAM address.
- `sram_wdata`  out  32  SRAM write data.
- `sram_data_oe`  out  1  1 = pad drivers enabled with `sram_wdata`.
- `sram_rdata`  in  32  SRAM read data from pads.
- `sram_ncs`, `sram_noe`, `sram_nwe`  out  1 each  active-low chip select, output enable, write enable.
- `sram_nbe`  out  4  active-low byte enables.

## Operation
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, READ, WSETUP, WSTROBE, WHOLD, ACK. A 4-bit down-counter times READ and WSTROBE.
- IDLE: `sram_ncs`=1, `sram_noe`=1, `sram_nwe`=1, `sram_nbe`=4'hf, `sram_data_oe`=0, `de_ack`=0. On an edge with `de_req`=1: latch `de_rnw`, `de_addr`, `de_nbyte` and `de_data`; drive `sram_addr` from the latched address; go to READ if rnw=1, otherwise WSETUP. Request inputs are ignored in every other state.
- READ (RD_WAIT cycles):
  - `sram_ncs`=0, `sram_noe`=0, `sram_nbe`=4'h0; `de_nbyte` is ignored and a full word is always read.
  - On the final READ edge, capture `sram_rdata` into `de_rd_data`, deassert `ncs`/`noe`, go to ACK.
- WSETUP (1 cycle): `sram_ncs`=0, `sram_data_oe`=1, `sram_wdata`=latched data, `sram_nwe`=1.
- WSTROBE (WR_WAIT cycles): `sram_nwe`=0, `sram_nbe`=latched nbyte. If the latched nbyte is 4'hf, `sram_nwe` stays 1 and the latency is unchanged.
- WHOLD (1 cycle): `sram_nwe`=1, `sram_nbe`=4'hf; address and data are still driven and `ncs`=0.
- ACK (1 cycle): `de_ack`=1; chip deselected and `sram_data_oe`=0; then IDLE.
- `de_rd_data` is never changed by writes.
- `sram_addr` and `sram_wdata` hold their last value when idle.

## Timing
- Accept edge = E0.
- Read: `noe` low in cycles E0+1..E0+RD_WAIT; `de_ack` high in the cycle after edge E0+RD_WAIT+1.
- Write:
  - `nwe` low in cycles E0+2..E0+WR_WAIT+1.
  - Data is driven from E0+1 through the WHOLD cycle, giving one cycle of setup and one of hold around the strobe.
  - `de_ack` high in the cycle after edge E0+WR_WAIT+3.
- After ACK there is always at least one IDLE cycle with `de_ack`=0, so the mux can re-steer its ack routing.
- The earliest next accept is the edge ending that IDLE cycle.
  - Back-to-back read throughput: one transaction per RD_WAIT+2 cycles.
  - Back-to-back write throughput: one transaction per WR_WAIT+4 cycles.
- Requester rule: `de_req` held with stable fields until accepted. The requester drops or changes `de_req` at the edge on which it sees `de_ack`=1. A `de_req` still high in the following IDLE cycle is taken as a new transaction.
- Reset asserted at any time, including mid-strobe:
  - Immediately forces IDLE.
  - Outputs go to: `de_ack`=0, `de_rd_data`=0, `sram_ncs`=`sram_noe`=`sram_nwe`=1, `sram_nbe`=4'hf, `sram_data_oe`=0, `sram_addr`=0, `sram_wdata`=0.
  - The aborted transaction is not acknowledged.
- The first accept can occur on the first rising edge after reset deasserts.

## Test plan
- Reset values: assert `reset` between edges → all outputs take their reset values without waiting for `clk`.
- Read, RD_WAIT=2: write SRAM model word 0x00123 = 0xDEADBEEF, then request a read of 0x00123.
  - `noe` is low for exactly 2 cycles.
  - `de_ack` pulses for one cycle, 3 cycles after accept, with `de_rd_data`=0xDEADBEEF.
- Byte write: write 0xAABBCCDD to 0x3FFFF with `de_nbyte`=4'b1010 over an old word of 0x11223344.
  - `nwe` is low for WR_WAIT cycles with `sram_nbe`=4'b1010.
  - Readback returns 0x11BB33DD.
  - `de_ack` arrives WR_WAIT+3 cycles after accept.
- Null write with `de_nbyte`=4'hf → `nwe` never falls, memory is unchanged, `de_ack` timing is identical to a normal write.
- Back-to-back with `de_req` held high across 3 reads → acks separated by exactly RD_WAIT+2 cycles, each followed by one `de_ack`=0 idle cycle; `de_rd_data` holds between acks.
- Reset in the second WSTROBE cycle → `nwe`/`ncs`/`data_oe` deassert asynchronously and no `de_ack` is produced. A new read accepted after reset completes normally.

Source files
------------

// File: rtl/de_sram_driver.sv
// de_sram_driver: drawing-engine memory responder for a 32-bit async SRAM.
// Takes one de_req transaction at a time. It runs a timed read or a
// setup/strobe/hold write on the SRAM pins, then returns a one-cycle de_ack.
// Every output is registered. The FSM state is exported on dbg_state for checkers.
//
// Handshake: de_req is a level request. The requester holds de_req and its
// fields stable until accepted. Acceptance is any rising edge where the FSM is
// IDLE and de_req=1. de_ack is a single-cycle completion pulse, and it is
// always followed by at least one IDLE cycle with de_ack=0. A de_req still high
// in that IDLE cycle is accepted as a new transaction on the edge that ends it.
module de_sram_driver #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de_req,
  output logic        de_ack,
  input  logic        de_rnw,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic [31:0] de_data,
  output logic [31:0] de_rd_data,
  output logic [17:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic        sram_data_oe,
  input  logic [31:0] sram_rdata,
  output logic        sram_ncs,
  output logic        sram_noe,
  output logic        sram_nwe,
  output logic [3:0]  sram_nbe,
  output logic [2:0]  dbg_state
);

  // Encoding is visible on dbg_state: 0 IDLE, 1 READ, 2 WSETUP, 3 WSTROBE, 4 WHOLD, 5 ACK
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WSETUP  = 3'd2,
    S_WSTROBE = 3'd3,
    S_WHOLD   = 3'd4,
    S_ACK     = 3'd5
  } state_t;

  // The down-counter reaches zero in the last cycle of READ or WSTROBE
  localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  nbyte_q, nbyte_d;
  logic [17:0] addr_d;
  logic [31:0] wdata_d;
  logic [31:0] rd_data_d;
  logic        ncs_d, noe_d, nwe_d, oe_d, ack_d;
  logic [3:0]  nbe_d;

  assign dbg_state = state_q;

  // Next state, latched request fields and the read-data capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nbyte_d   = nbyte_q;
    addr_d    = sram_addr;
    wdata_d   = sram_wdata;
    rd_data_d = de_rd_data;
    case (state_q)
      S_IDLE: begin
        if (de_req) begin
          addr_d  = de_addr;
          nbyte_d = de_nbyte;
          if (de_rnw) begin
            state_d = S_READ;
            cnt_d   = RD_CNT;
          end else begin
            state_d = S_WSETUP;
            wdata_d = de_data;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 4'd0) begin
          rd_data_d = sram_rdata;
          state_d   = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WSETUP: begin
        state_d = S_WSTROBE;
        cnt_d   = WR_CNT;
      end
      S_WSTROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_WHOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WHOLD: state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values for the coming cycle are decoded from the next state, so the pins can be registered
  always_comb begin
    ncs_d = 1'b1;
    noe_d = 1'b1;
    nwe_d = 1'b1;
    oe_d  = 1'b0;
    nbe_d = 4'hf;
    ack_d = 1'b0;
    case (state_d)
      S_READ: begin
        ncs_d = 1'b0;
        noe_d = 1'b0;
        nbe_d = 4'h0;
      end
      S_WSETUP: begin
        ncs_d = 1'b0;
        oe_d  = 1'b1;
      end
      S_WSTROBE: begin
        ncs_d = 1'b0;
        oe_d  = 1'b1;
        nbe_d = nbyte_d;
        // With no lanes enabled the strobe is suppressed, but the timing is unchanged
        nwe_d = (nbyte_d == 4'hf);
      end
      S_WHOLD: begin
        ncs_d = 1'b0;
        oe_d  = 1'b1;
      end
      S_ACK:   ack_d = 1'b1;
      default: ack_d = 1'b0;
    endcase
  end

  // State, counter and latched byte enables
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      nbyte_q <= 4'hf;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nbyte_q <= nbyte_d;
    end
  end

  // Registered pins and requester outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_ack       <= 1'b0;
      de_rd_data   <= 32'h0;
      sram_addr    <= 18'h0;
      sram_wdata   <= 32'h0;
      sram_data_oe <= 1'b0;
      sram_ncs     <= 1'b1;
      sram_noe     <= 1'b1;
      sram_nwe     <= 1'b1;
      sram_nbe     <= 4'hf;
    end else begin
      de_ack       <= ack_d;
      de_rd_data   <= rd_data_d;
      sram_addr    <= addr_d;
      sram_wdata   <= wdata_d;
      sram_data_oe <= oe_d;
      sram_ncs     <= ncs_d;
      sram_noe     <= noe_d;
      sram_nwe     <= nwe_d;
      sram_nbe     <= nbe_d;
    end
  end

endmodule

// File: tb/tb_de_sram_driver.sv
// tb_de_sram_driver: drives de_sram_driver against a behavioural async SRAM.
// Pin timing, read data and memory contents are checked against a reference
// model that is derived from the transaction rules.
module tb_de_sram_driver;

  localparam int R = 2;
  localparam int W = 3;

  logic        clk;
  logic        reset;
  logic        de_req;
  logic        de_ack;
  logic        de_rnw;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [31:0] de_data;
  logic [31:0] de_rd_data;
  logic [17:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_data_oe;
  logic [31:0] sram_rdata;
  logic        sram_ncs;
  logic        sram_noe;
  logic        sram_nwe;
  logic [3:0]  sram_nbe;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Physical SRAM contents and the reference model's view of them
  logic [31:0] mem     [logic [17:0]];
  logic [31:0] ref_mem [logic [17:0]];
  logic [31:0] ref_rd;

  de_sram_driver #(.RD_WAIT(R), .WR_WAIT(W)) dut (
    .clk(clk), .reset(reset), .de_req(de_req), .de_ack(de_ack),
    .de_rnw(de_rnw), .de_addr(de_addr), .de_nbyte(de_nbyte), .de_data(de_data),
    .de_rd_data(de_rd_data), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_data_oe(sram_data_oe), .sram_rdata(sram_rdata), .sram_ncs(sram_ncs),
    .sram_noe(sram_noe), .sram_nwe(sram_nwe), .sram_nbe(sram_nbe),
    .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] peek(input logic [17:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_peek(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] nb);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (!nb[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  // Expected {ncs,noe,nwe,data_oe,nbe,ack} in cycle k after the accept edge
  function automatic logic [8:0] exp_ctl(input logic rnw, input logic [3:0] nb, input int k);
    logic [8:0] idle_v;
    idle_v = {1'b1, 1'b1, 1'b1, 1'b0, 4'hf, 1'b0};
    if (rnw) begin
      if (k <= R)     return {1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0};
      if (k == R + 1) return {1'b1, 1'b1, 1'b1, 1'b0, 4'hf, 1'b1};
      return idle_v;
    end
    if (k == 1)      return {1'b0, 1'b1, 1'b1, 1'b1, 4'hf, 1'b0};
    if (k <= W + 1)  return {1'b0, 1'b1, (nb == 4'hf), 1'b1, nb, 1'b0};
    if (k == W + 2)  return {1'b0, 1'b1, 1'b1, 1'b1, 4'hf, 1'b0};
    if (k == W + 3)  return {1'b1, 1'b1, 1'b1, 1'b0, 4'hf, 1'b1};
    return idle_v;
  endfunction

  // SRAM model: lanes are written while nwe is low; read data is presented while noe is low
  always @(posedge clk) begin
    if (!sram_ncs && !sram_nwe && sram_data_oe)
      mem[sram_addr] = merge(peek(sram_addr), sram_wdata, sram_nbe);
  end

  always @(negedge clk) begin
    sram_rdata = (!sram_ncs && !sram_noe) ? peek(sram_addr) : 32'hbad0_bad0;
  end

  // Driver: one transaction, accepted on the next rising edge, checked every cycle
  // through the ACK cycle and the IDLE cycle that follows it
  task automatic run_txn(input logic rnw, input logic [17:0] addr, input logic [3:0] nb,
                         input logic [31:0] data, input bit keep_req, output time ack_t);
    int len;
    logic [8:0] got_v, exp_v;
    logic [31:0] new_rd, exp_rd;
    len = rnw ? R + 1 : W + 3;
    new_rd = rnw ? ref_peek(addr) : ref_rd;
    ack_t = 0;
    de_req = 1'b1; de_rnw = rnw; de_addr = addr; de_nbyte = nb; de_data = data;
    for (int k = 1; k <= len + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      got_v = {sram_ncs, sram_noe, sram_nwe, sram_data_oe, sram_nbe, de_ack};
      exp_v = exp_ctl(rnw, nb, k);
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL ctl rnw=%0b addr=%h k=%0d: got ncs/noe/nwe/oe/nbe/ack=%b required %b",
                 rnw, addr, k, got_v, exp_v);
      end
      n_checks++;
      if (sram_addr !== addr) begin
        n_fail++;
        $display("FAIL sram_addr k=%0d: got %h required %h", k, sram_addr, addr);
      end
      if (!rnw) begin
        n_checks++;
        if (sram_wdata !== data) begin
          n_fail++;
          $display("FAIL sram_wdata k=%0d: got %h required %h", k, sram_wdata, data);
        end
      end
      exp_rd = (k >= len) ? new_rd : ref_rd;
      n_checks++;
      if (de_rd_data !== exp_rd) begin
        n_fail++;
        $display("FAIL de_rd_data k=%0d: got %h required %h", k, de_rd_data, exp_rd);
      end
      if (k == len) begin
        ack_t = $time;
        if (!keep_req) de_req = 1'b0;
      end
    end
    if (rnw) ref_rd = new_rd;
    else ref_mem[addr] = merge(ref_peek(addr), data, nb);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [8:0] got_v;
    got_v = {sram_ncs, sram_noe, sram_nwe, sram_data_oe, sram_nbe, de_ack};
    n_checks++;
    if (got_v !== 9'b1_1_1_0_1111_0) begin
      n_fail++;
      $display("FAIL %s ctl: got %b required 111011110", tag, got_v);
    end
    n_checks++;
    if ({sram_addr, sram_wdata, de_rd_data} !== 82'h0) begin
      n_fail++;
      $display("FAIL %s data: got addr=%h wdata=%h rd=%h required all zero",
               tag, sram_addr, sram_wdata, de_rd_data);
    end
  endtask

  task automatic test_reset();
    de_req = 1'b0; de_rnw = 1'b0; de_addr = '0; de_nbyte = 4'hf; de_data = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_async");
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required 0 (IDLE)", dbg_state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_rd = 32'h0;
  endtask

  task automatic test_read_basic();
    time t;
    mem[18'h00123] = 32'hdead_beef;
    ref_mem[18'h00123] = 32'hdead_beef;
    run_txn(1'b1, 18'h00123, 4'h5, 32'h0, 1'b0, t);
  endtask

  task automatic test_byte_write();
    time t;
    mem[18'h3ffff] = 32'h1122_3344;
    ref_mem[18'h3ffff] = 32'h1122_3344;
    run_txn(1'b0, 18'h3ffff, 4'b1010, 32'haabb_ccdd, 1'b0, t);
    run_txn(1'b1, 18'h3ffff, 4'h0, 32'h0, 1'b0, t);
    n_checks++;
    if (ref_rd !== 32'h11bb_33dd) begin
      n_fail++;
      $display("FAIL byte_merge_model: got %h required 11bb33dd", ref_rd);
    end
  endtask

  task automatic test_null_write();
    time t;
    mem[18'h00777] = 32'h5a5a_1234;
    ref_mem[18'h00777] = 32'h5a5a_1234;
    run_txn(1'b0, 18'h00777, 4'hf, 32'hffff_ffff, 1'b0, t);
    run_txn(1'b1, 18'h00777, 4'h0, 32'h0, 1'b0, t);
  endtask

  task automatic test_back_to_back();
    time t[3];
    logic [17:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 18'h01000 + 18'(i);
      mem[a] = $urandom;
      ref_mem[a] = mem[a];
    end
    for (int i = 0; i < 3; i++)
      run_txn(1'b1, 18'h01000 + 18'(i), 4'h0, 32'h0, (i < 2), t[i]);
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (t[i] - t[i-1] != (R + 2) * 10) begin
        n_fail++;
        $display("FAIL b2b_spacing %0d: got %0t required %0d", i, t[i] - t[i-1], (R + 2) * 10);
      end
    end
  endtask

  task automatic test_random();
    time t;
    logic [17:0] pool[6];
    logic rnw;
    logic [17:0] a;
    pool[0] = 18'h00000; pool[1] = 18'h00001; pool[2] = 18'h2aaaa;
    pool[3] = 18'h15555; pool[4] = 18'h3fffe; pool[5] = 18'h00123;
    for (int i = 0; i < 40; i++) begin
      rnw = 1'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 5)];
      run_txn(rnw, a, 4'($urandom_range(0, 15)), $urandom, 1'b0, t);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_strobe();
    time t;
    int acks;
    de_req = 1'b1; de_rnw = 1'b0; de_addr = 18'h00055; de_nbyte = 4'h0; de_data = 32'hcafe_f00d;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    // Cycle 3 is the second strobe cycle
    n_checks++;
    if (sram_nwe !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_strobe_nwe: got %b required 0", sram_nwe);
    end
    de_req = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_strobe");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_rd = 32'h0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (de_ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL aborted_ack: got %0d acks required 0", acks);
    end
    run_txn(1'b1, 18'h00123, 4'h0, 32'h0, 1'b0, t);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_byte_write();
    test_null_write();
    test_back_to_back();
    test_random();
    test_reset_mid_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
